// File: rtl/accum_buf_ctrl_pkg.sv
// Shared types and helpers for the accumulation buffer interval sequencer.
package accum_buf_ctrl_pkg;

    function automatic int bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SWITCH
    } accum_ctrl_state_t;

    typedef enum logic [1:0] {
        STORE,
        DRAIN,
        LOAD,
        BDONE
    } accum_b_state_t;

endpackage

// File: rtl/RQ.sv
// Reset queue: fixed-latency delay line whose contents clear on reset.
module RQ #(
    parameter int DW = 2,
    parameter int L  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] pipe_q [L];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[L-1];

endmodule

// File: rtl/accum_sweep.sv
// Length-bounded address counter; holds at len-1 instead of wrapping.
module accum_sweep #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [ADDR_W:0] len_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic            done_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last;

    assign last = ({1'b0, cnt_q} + (ADDR_W+1)'(1)) == len_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !last) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i && last;

endmodule

// File: rtl/accum_buf_ctrl.sv
// Ping-pong interval sequencer for the PE accumulation buffer.
// Define ACCUM_CTRL_TAIL_LOAD_EN to take the tail from the load stream.
module accum_buf_ctrl
    import accum_buf_ctrl_pkg::*;
#(
    parameter  int DEPTH  = 256,
    parameter  int RD_LAT = 2,
    localparam int ADDR_W = bw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_acc,
    input  logic [ADDR_W:0]   cfg_st_len,
    input  logic [ADDR_W:0]   cfg_ld_len,
    output logic              acc_start,
    input  logic              acc_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              st_ready,
    output logic              st_valid,
    output logic              st_last,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data_en,
    output logic              wr_tail_en,
    output logic              wr_tail_zero,
    output logic              switch,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    accum_ctrl_state_t state_q;
    accum_b_state_t    b_q;
    logic [ADDR_W:0]   st_len_q, ld_len_q;
    logic [ADDR_W:0]   st_cl, ld_cl;
    logic              a_done_q, acc_start_q, switch_q;
    logic              cfg_ready_q, busy_q;
    logic              hs, in_run, a_fin;
    logic              st_issue, st_fin, ld_fire, ld_fin;

    assign st_cl = (cfg_st_len > DEPTH_L) ? DEPTH_L : cfg_st_len;
    assign ld_cl = (cfg_ld_len > DEPTH_L) ? DEPTH_L : cfg_ld_len;

    assign hs       = (state_q == IDLE) && cfg_valid;
    assign in_run   = (state_q == RUN);
    assign a_fin    = a_done_q || acc_done;
    assign st_issue = in_run && (b_q == STORE) && st_ready;
    assign ld_ready = in_run && (b_q == LOAD);
    assign ld_fire  = ld_ready && ld_valid;

    accum_sweep #(.ADDR_W(ADDR_W)) u_st_sweep (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (hs),
        .en_i   (st_issue),
        .len_i  (st_len_q),
        .cnt_o  (rd_addr),
        .done_o (st_fin)
    );

    accum_sweep #(.ADDR_W(ADDR_W)) u_ld_sweep (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (hs),
        .en_i   (ld_fire),
        .len_i  (ld_len_q),
        .cnt_o  (wr_addr),
        .done_o (ld_fin)
    );

    RQ #(.DW(2), .L(RD_LAT)) u_st_rq (
        .clk (clk),
        .rst (rst),
        .d_i ({st_issue, st_fin}),
        .q_o ({st_valid, st_last})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            b_q         <= STORE;
            st_len_q    <= '0;
            ld_len_q    <= '0;
            a_done_q    <= 1'b0;
            acc_start_q <= 1'b0;
            switch_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            acc_start_q <= 1'b0;
            switch_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        state_q     <= RUN;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        acc_start_q <= cfg_acc;
                        a_done_q    <= !cfg_acc;
                        st_len_q    <= st_cl;
                        ld_len_q    <= ld_cl;
                        b_q <= (st_cl != '0) ? STORE :
                               (ld_cl != '0) ? LOAD : BDONE;
                    end
                end
                RUN: begin
                    if (acc_done) a_done_q <= 1'b1;
                    case (b_q)
                        STORE: if (st_fin) b_q <= DRAIN;
                        // last issued read has surfaced on the data port
                        DRAIN: if (st_last)
                            b_q <= (ld_len_q != '0) ? LOAD : BDONE;
                        LOAD:  if (ld_fin) b_q <= BDONE;
                        default: ;
                    endcase
                    if (a_fin && b_q == BDONE) begin
                        state_q  <= SWITCH;
                        switch_q <= 1'b1;
                    end
                end
                SWITCH: begin
                    state_q     <= IDLE;
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign busy       = busy_q;
    assign acc_start  = acc_start_q;
    assign switch     = switch_q;
    assign wr_data_en = ld_fire;
    assign wr_tail_en = ld_fire;

`ifdef ACCUM_CTRL_TAIL_LOAD_EN
    assign wr_tail_zero = 1'b0;
`else
    assign wr_tail_zero = 1'b1;
`endif

endmodule

// File: tb/tb_accum_buf_ctrl.sv
// Directed self-checking bench for accum_buf_ctrl (DEPTH=256, RD_LAT=2).
module tb_accum_buf_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_ready, cfg_acc;
    logic [8:0] cfg_st_len, cfg_ld_len;
    logic       acc_start, acc_done;
    logic [7:0] rd_addr, wr_addr;
    logic       st_ready, st_valid, st_last;
    logic       ld_valid, ld_ready;
    logic       wr_data_en, wr_tail_en, wr_tail_zero;
    logic       switch, busy;

    int checks   = 0;
    int failures = 0;

`ifdef ACCUM_CTRL_TAIL_LOAD_EN
    localparam logic TZ = 1'b0;
`else
    localparam logic TZ = 1'b1;
`endif

    accum_buf_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_acc      (cfg_acc),
        .cfg_st_len   (cfg_st_len),
        .cfg_ld_len   (cfg_ld_len),
        .acc_start    (acc_start),
        .acc_done     (acc_done),
        .rd_addr      (rd_addr),
        .st_ready     (st_ready),
        .st_valid     (st_valid),
        .st_last      (st_last),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .wr_addr      (wr_addr),
        .wr_data_en   (wr_data_en),
        .wr_tail_en   (wr_tail_en),
        .wr_tail_zero (wr_tail_zero),
        .switch       (switch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Handshake in a fresh cycle t; returns settled in cycle t+1.
    task automatic start(input logic acc, input int st, input int ld);
        cyc();
        cfg_valid  = 1'b1;
        cfg_acc    = acc;
        cfg_st_len = 9'(st);
        cfg_ld_len = 9'(ld);
        settle();
        chk("hs_cfg_ready", cfg_ready, 1);
        cyc();
        cfg_valid = 1'b0;
        settle();
    endtask

    task automatic idle_out(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_outs"},
            {busy, switch, acc_start, st_valid, st_last, ld_ready,
             wr_data_en, wr_tail_en, rd_addr, wr_addr}, 0);
        chk({tag, "_tail_zero"}, wr_tail_zero, TZ);
    endtask

    initial begin
        int sw_cnt, issued, beats;
        logic [1:0] pipe;
        logic exp_v, done;
        logic [5:0] ldpat;

        rst = 1'b1; cfg_valid = 0; cfg_acc = 0;
        cfg_st_len = 0; cfg_ld_len = 0; acc_done = 0;
        st_ready = 0; ld_valid = 0;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        idle_out("reset");

        // accumulate only, acc_done 10 cycles after acc_start
        start(1'b1, 0, 0);
        chk("t1_acc_start", acc_start, 1);
        chk("t1_busy", busy, 1);
        chk("t1_cfg_ready", cfg_ready, 0);
        sw_cnt = 0;
        for (int i = 2; i <= 10; i++) begin
            cyc(); settle();
            sw_cnt += int'(switch);
        end
        chk("t1_no_early_switch", sw_cnt, 0);
        cyc(); acc_done = 1'b1; settle();
        chk("t1_sw_at_done", switch, 0);
        cyc(); acc_done = 1'b0; settle();
        chk("t1_switch", switch, 1);
        cyc(); settle();
        chk("t1_switch_once", switch, 0);
        chk("t1_cfg_ready_back", cfg_ready, 1);

        // minimum interval
        start(1'b0, 0, 0);
        chk("min_t1_switch", switch, 0);
        cyc(); settle();
        chk("min_t2_switch", switch, 1);

        // acc_done in IDLE ignored, acc_done with acc_start counts
        cyc(); acc_done = 1'b1; settle();
        cyc(); acc_done = 1'b0; settle();
        start(1'b1, 0, 0);
        chk("idle_done_ignored_a", switch, 0);
        cyc(); settle();
        chk("idle_done_ignored_b", switch, 0);
        acc_done = 1'b1;
        cyc(); acc_done = 1'b0; settle();
        chk("idle_done_late_sw", switch, 1);
        start(1'b1, 0, 0);
        acc_done = 1'b1;
        cyc(); acc_done = 1'b0; settle();
        chk("same_cycle_done_sw", switch, 1);

        // store 4, st_ready high
        st_ready = 1'b1;
        start(1'b0, 4, 0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin cyc(); settle(); end
            if (k <= 4) chk($sformatf("t2_rd_addr%0d", k), rd_addr, k - 1);
            chk($sformatf("t2_st_valid%0d", k), st_valid, (k >= 3) ? 1 : 0);
            chk($sformatf("t2_st_last%0d", k), st_last, (k == 6) ? 1 : 0);
        end
        cyc(); settle();
        chk("t2_sw_t7", switch, 0);
        cyc(); settle();
        chk("t2_sw_t8", switch, 1);
        cyc(); settle();
        chk("t2_ready_t9", cfg_ready, 1);

        // store 8 with toggling st_ready, then gappy load of 3
        pipe = 2'b00; issued = 0; beats = 0; done = 1'b0;
        st_ready = 1'b0;
        start(1'b0, 8, 3);
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k > 1) cyc();
            st_ready = k[0];
            settle();
            chk($sformatf("t3_ld_ready_k%0d", k), ld_ready, 0);
            exp_v = pipe[1];
            pipe = {pipe[0], 1'b0};
            if (st_ready && issued < 8) begin
                chk($sformatf("t3_rd_addr%0d", issued), rd_addr, issued);
                issued++;
                pipe[0] = 1'b1;
            end
            chk($sformatf("t3_st_valid_k%0d", k), st_valid, exp_v);
            chk($sformatf("t3_st_last_k%0d", k), st_last,
                (exp_v && beats == 7) ? 1 : 0);
            if (exp_v) beats++;
            if (beats == 8) done = 1'b1;
        end
        chk("t3_store_finished", done, 1);
        st_ready = 1'b0;
        ldpat = 6'b100101;
        issued = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            ld_valid = ldpat[k];
            settle();
            chk($sformatf("t4_ld_ready%0d", k), ld_ready, 1);
            chk($sformatf("t4_wr_en%0d", k), {wr_data_en, wr_tail_en},
                ldpat[k] ? 2'b11 : 2'b00);
            chk($sformatf("t4_tail_zero%0d", k), wr_tail_zero, TZ);
            if (ldpat[k]) begin
                chk($sformatf("t4_wr_addr%0d", issued), wr_addr, issued);
                issued++;
            end
            chk($sformatf("t4_sw%0d", k), switch, 0);
        end
        cyc(); ld_valid = 1'b0; settle();
        chk("t4_ld_ready_off", ld_ready, 0);
        chk("t4_sw_bdone", switch, 0);
        cyc(); settle();
        chk("t4_switch", switch, 1);

        // clamp: length DEPTH+5
        st_ready = 1'b1;
        start(1'b0, 261, 0);
        for (int k = 1; k <= 256; k++) begin
            if (k > 1) begin cyc(); settle(); end
            chk($sformatf("t5_rd_addr%0d", k - 1), rd_addr, k - 1);
        end
        cyc(); settle();
        chk("t5_st_valid_257", st_valid, 1);
        chk("t5_rd_hold", rd_addr, 255);
        cyc(); settle();
        chk("t5_st_last_258", {st_valid, st_last}, 2'b11);
        cyc(); settle();
        chk("t5_no_extra_beat", st_valid, 0);
        cyc(); settle();
        chk("t5_switch", switch, 1);

        // reset mid-STORE
        start(1'b0, 6, 0);
        chk("t6_rd0", rd_addr, 0);
        cyc(); settle();
        chk("t6_rd1", rd_addr, 1);
        cyc(); rst = 1'b1; settle();
        chk("t6_pre_rst_valid", st_valid, 1);
        cyc(); rst = 1'b0; settle();
        idle_out("t6_after_rst");
        sw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); settle();
            sw_cnt += int'(switch) + int'(st_valid) + int'(busy);
        end
        chk("t6_quiet_after_rst", sw_cnt, 0);
        st_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
